ysyx_22050019_pc_gen: RTL and testbench
=======================================

// Module: ysyx_22050019_pc_gen
// PURPOSE
//  Fetch-address generator, directly upstream of the IFU. Owns the architectural fetch PC.
//  Drives inst_addr_o into IFU inst_addr_i with a valid/ready handshake.
//  Selects the next PC from: trap vector (CSR), redirect (EXU branch/jump), stall hold, or sequential +4.
//  Detects misaligned redirect targets, parks until the trap path supplies a handler address.
// PARAMETERS
//  RESET_PC   64'h0000_0000_8000_0000  first fetch address after reset
//  INST_BYTES 4                        sequential PC increment
// PORTS
//  clk             in   1   single clock, all state updates on rising edge
//  rst_n           in   1   reset; synchronous, active-high (1 = reset asserted)
//  redirect_valid_i in  1   EXU branch/jump taken this cycle
//  redirect_pc_i   in   64  redirect target
//  trap_valid_i    in   1   CSR trap/mret this cycle
//  trap_pc_i       in   64  mtvec/mepc target
//  stall_i         in   1   downstream hazard; hold current PC
//  ifu_ready_i     in   1   IFU accepts inst_addr_o this cycle
//  inst_addr_o     out  64  fetch address to IFU
//  pc_valid_o      out  1   inst_addr_o is a valid fetch request
//  flush_o         out  1   kill the instruction held in the IFU pipeline register
//  misalign_o      out  1   redirect target misaligned (1-cycle pulse)
//  misalign_pc_o   out  64  offending target, valid while misalign_o=1
// BEHAVIOUR
//  - Reset (rst_n=1 at edge): pc_q=RESET_PC, state=BOOT, pc_valid_o=0, flush_o=0, misalign_o=0, misalign_pc_o=0.
//  - States: BOOT -> RUN (unconditional, 1 cycle); RUN -> WAIT_TRAP on misaligned redirect; WAIT_TRAP -> RUN on trap_valid_i.
//  - pc_valid_o=1 only in RUN; inst_addr_o=pc_q in all states.
//  - fire = pc_valid_o & ifu_ready_i & ~stall_i. In RUN, no redirect/trap: on fire pc_q<=pc_q+INST_BYTES.
//    Arithmetic is 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
//  - Without fire, pc_q holds. While pc_valid_o & ~ifu_ready_i, inst_addr_o stays stable.
//    Exception: an accepted redirect/trap.
//  - Priority per cycle: trap > redirect > stall > sequential. Lower-priority events in the same cycle are dropped.
//  - Trap (any state but BOOT): pc_q<=trap_pc_i & ~64'h3 (low mode bits cleared), state<=RUN. flush_o=1 this cycle.
//  - Redirect (RUN only, ignored in BOOT/WAIT_TRAP), accepted regardless of stall_i/ifu_ready_i.
//    Aligned (redirect_pc_i[1:0]==0): pc_q<=redirect_pc_i next edge; flush_o=1 this cycle (combinational).
//    Misaligned: pc_q holds; state<=WAIT_TRAP.
//      misalign_o<=1 for exactly one cycle (registered, the cycle after detection).
//      misalign_pc_o<=redirect_pc_i; flush_o=1 this cycle.
//  - flush_o = (trap accepted) | (redirect accepted); never asserted in BOOT or during reset.
//  - Latency: redirect/trap in cycle N -> new inst_addr_o visible in cycle N+1 with pc_valid_o=1 (if RUN).
//  - Reset mid-operation dominates everything: same cycle inputs ignored, return to BOOT state above.
// STRUCTURE
//  - Shared package ysyx_22050019_pkg: RESET_PC default, INST_BYTES, state encoding (BOOT=2'd0, RUN=2'd1, WAIT_TRAP=2'd2).
//  - One sub-module: ysyx_22050019_npc_mux.
//    Purely combinational priority select of next PC plus the flush/misalign decode.
//    FSM and registers stay in this module.
// TESTING
//  1 Reset then release, ifu_ready_i=1: cyc1 pc_valid_o=0; cyc2 0x8000_0000; then 0x8000_0004, 0x8000_0008.
//  2 Back-pressure: ifu_ready_i=0 for 3 cycles at 0x8000_0008 -> address stable, valid=1; then resumes 0x8000_000C.
//    stall_i=1 alone gives the same hold.
//  3 redirect_valid_i=1, pc=0x8000_0100 during stall_i=1 -> flush_o=1 same cycle; next cycle inst_addr_o=0x8000_0100.
//  4 Same cycle trap 0x8000_0201 + redirect 0x8000_0300 -> flush_o=1; next cycle inst_addr_o=0x8000_0200.
//  5 redirect 0x8000_0102 -> flush_o=1; next cycle misalign_o=1 (one cycle), misalign_pc_o=0x8000_0102.
//    pc_valid_o=0 until trap 0x8000_1000 -> RUN at 0x8000_1000; redirects in WAIT_TRAP ignored.
//  6 Wrap: trap to 0xFFFF_FFFF_FFFF_FFFC, fire -> 0x0.
//    Assert rst_n mid-stall -> next cycle pc_valid_o=0, following cycle 0x8000_0000.

Source files
------------

// File: rtl/ysyx_22050019_pkg.sv
// Shared definitions for the fetch-address generator: reset vector, instruction size
// and fetch FSM state encoding.
package ysyx_22050019_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT   = 64'h0000_0000_8000_0000;
  localparam int unsigned INST_BYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    StBoot     = 2'd0,
    StRun      = 2'd1,
    StWaitTrap = 2'd2
  } pc_state_e;

endpackage

// File: rtl/ysyx_22050019_npc_mux.sv
// Next-PC priority select (trap > redirect > sequential > hold) plus flush and
// misaligned-redirect decode. Purely combinational; all state lives in the parent.
module ysyx_22050019_npc_mux
  import ysyx_22050019_pkg::*;
#(
  parameter int unsigned INST_BYTES = INST_BYTES_DEFAULT
) (
  input  pc_state_e   state_i,
  input  logic [63:0] pc_i,
  input  logic        fire_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        trap_valid_i,
  input  logic [63:0] trap_pc_i,
  output logic [63:0] pc_next_o,
  output logic        trap_take_o,
  output logic        flush_o,
  output logic        misalign_o
);

  logic redir_take;

  // Accept decode and priority select of the next fetch PC
  always_comb begin
    trap_take_o = trap_valid_i & (state_i != StBoot);
    // Redirects only matter in RUN and lose to a same-cycle trap
    redir_take  = redirect_valid_i & (state_i == StRun) & ~trap_take_o;
    misalign_o  = redir_take & (redirect_pc_i[1:0] != 2'b00);
    flush_o     = trap_take_o | redir_take;

    pc_next_o = pc_i;
    if (trap_take_o) begin
      // Low bits of mtvec carry the vector mode, not address
      pc_next_o = trap_pc_i & ~64'h3;
    end else if (redir_take) begin
      // A misaligned target parks the PC until the trap handler address arrives
      pc_next_o = misalign_o ? pc_i : redirect_pc_i;
    end else if (fire_i) begin
      pc_next_o = pc_i + 64'(INST_BYTES);
    end
  end

endmodule

// File: rtl/ysyx_22050019_pc_gen.sv
// Fetch-address generator: owns the architectural fetch PC and presents it to the IFU
// with a valid/ready handshake, handling traps, redirects, stalls and misaligned targets.
module ysyx_22050019_pc_gen
  import ysyx_22050019_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned INST_BYTES = INST_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        trap_valid_i,
  input  logic [63:0] trap_pc_i,
  input  logic        stall_i,
  input  logic        ifu_ready_i,
  output logic [63:0] inst_addr_o,
  output logic        pc_valid_o,
  output logic        flush_o,
  output logic        misalign_o,
  output logic [63:0] misalign_pc_o
);

  pc_state_e   state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        misalign_q;
  logic [63:0] misalign_pc_q;
  logic        fire;
  logic        trap_take;
  logic        flush_raw;
  logic        misalign_det;

  ysyx_22050019_npc_mux #(
    .INST_BYTES (INST_BYTES)
  ) u_npc_mux (
    .state_i          (state_q),
    .pc_i             (pc_q),
    .fire_i           (fire),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .trap_valid_i     (trap_valid_i),
    .trap_pc_i        (trap_pc_i),
    .pc_next_o        (pc_d),
    .trap_take_o      (trap_take),
    .flush_o          (flush_raw),
    .misalign_o       (misalign_det)
  );

  // FSM state register; rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: BOOT lasts one cycle, misaligned redirect parks until a trap
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:     state_d = StRun;
      StRun:      if (!trap_take && misalign_det) state_d = StWaitTrap;
      StWaitTrap: if (trap_take) state_d = StRun;
      default:    state_d = StBoot;
    endcase
  end

  // FSM outputs and handshake decode
  always_comb begin
    pc_valid_o    = (state_q == StRun);
    fire          = pc_valid_o & ifu_ready_i & ~stall_i;
    // Reset in the same cycle must not kill anything downstream
    flush_o       = flush_raw & ~rst_n;
    inst_addr_o   = pc_q;
    misalign_o    = misalign_q;
    misalign_pc_o = misalign_pc_q;
  end

  // PC and misalign report registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q          <= RESET_PC;
      misalign_q    <= 1'b0;
      misalign_pc_q <= 64'h0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_det;
      if (misalign_det) begin
        misalign_pc_q <= redirect_pc_i;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_pc_gen.sv
// Self-checking bench for the fetch-address generator: table of per-cycle vectors with
// expected outputs pushed to a scoreboard queue and checked mid-cycle by a monitor.
module tb_ysyx_22050019_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        trap_valid_i;
  logic [63:0] trap_pc_i;
  logic        stall_i;
  logic        ifu_ready_i;
  logic [63:0] inst_addr_o;
  logic        pc_valid_o;
  logic        flush_o;
  logic        misalign_o;
  logic [63:0] misalign_pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22050019_pc_gen dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .trap_valid_i     (trap_valid_i),
    .trap_pc_i        (trap_pc_i),
    .stall_i          (stall_i),
    .ifu_ready_i      (ifu_ready_i),
    .inst_addr_o      (inst_addr_o),
    .pc_valid_o       (pc_valid_o),
    .flush_o          (flush_o),
    .misalign_o       (misalign_o),
    .misalign_pc_o    (misalign_pc_o)
  );

  typedef struct {
    int          idx;
    logic        rst;
    logic        rv;
    logic [63:0] rpc;
    logic        tv;
    logic [63:0] tpc;
    logic        stall;
    logic        rdy;
    logic        chk;
    logic        chk_mpc;
    logic [63:0] e_addr;
    logic        e_valid;
    logic        e_flush;
    logic        e_mis;
    logic [63:0] e_mpc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   row = 0;

  function automatic vec_t mk(logic rst, logic rv, logic [63:0] rpc, logic tv,
                              logic [63:0] tpc, logic stall, logic rdy, logic chk,
                              logic chk_mpc, logic [63:0] e_addr, logic e_valid,
                              logic e_flush, logic e_mis, logic [63:0] e_mpc);
    vec_t v;
    v.idx = 0; v.rst = rst; v.rv = rv; v.rpc = rpc; v.tv = tv; v.tpc = tpc;
    v.stall = stall; v.rdy = rdy; v.chk = chk; v.chk_mpc = chk_mpc;
    v.e_addr = e_addr; v.e_valid = e_valid; v.e_flush = e_flush; v.e_mis = e_mis;
    v.e_mpc = e_mpc;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got %h, expected %h", idx, name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the edge and queue its expectation
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst_n            = v.rst;
    redirect_valid_i = v.rv;
    redirect_pc_i    = v.rpc;
    trap_valid_i     = v.tv;
    trap_pc_i        = v.tpc;
    stall_i          = v.stall;
    ifu_ready_i      = v.rdy;
    v.idx            = row;
    row++;
    sb.push_back(v);
  endtask

  // Outputs are sampled at the falling edge, mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t v;
      v = sb.pop_front();
      if (v.chk) begin
        cmp("inst_addr", v.idx, inst_addr_o, v.e_addr);
        cmp("pc_valid", v.idx, 64'(pc_valid_o), 64'(v.e_valid));
        cmp("flush", v.idx, 64'(flush_o), 64'(v.e_flush));
        cmp("misalign", v.idx, 64'(misalign_o), 64'(v.e_mis));
        if (v.chk_mpc) cmp("misalign_pc", v.idx, misalign_pc_o, v.e_mpc);
      end
    end
  end

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  initial begin
    int waited;
    rst_n = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0; trap_valid_i = 1'b0;
    trap_pc_i = '0; stall_i = 1'b0; ifu_ready_i = 1'b0;

    //              rst rv rpc           tv tpc           st rdy chk mpc addr      v  f  m  mpc
    tbl.push_back(mk(1, 0, 0,            0, 0,            0, 1,  0,  0, 0,        0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            0, 1,  1,  1, B,        0, 0, 0, 0));
    // Reset release: one BOOT cycle then sequential fetch
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1,  1,  1, B,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1,  1,  0, B,        1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1,  1,  0, B + 4,    1, 0, 0, 0));
    // Back-pressure at +8
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  1,  0, B + 8,    1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  1,  0, B + 8,    1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  1,  0, B + 8,    1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1,  1,  0, B + 8,    1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1,  1,  0, B + 12,   1, 0, 0, 0));
    // Stall alone holds
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 1,  1,  0, B + 16,   1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 1,  1,  0, B + 16,   1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1,  1,  0, B + 16,   1, 0, 0, 0));
    // Redirect during stall
    tbl.push_back(mk(0, 1, B + 'h100,    0, 0,            1, 1,  1,  0, B + 20,   1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  1,  0, B + 'h100, 1, 0, 0, 0));
    // Trap beats redirect, low bits cleared
    tbl.push_back(mk(0, 1, B + 'h300,    1, B + 'h201,    0, 0,  1,  0, B + 'h100, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  1,  0, B + 'h200, 1, 0, 0, 0));
    // Misaligned redirect: PC holds despite ready, then one-cycle misalign pulse
    tbl.push_back(mk(0, 1, B + 'h102,    0, 0,            0, 1,  1,  0, B + 'h200, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, B + 'h400,    0, 0,            0, 1,  1,  1, B + 'h200, 0, 0, 1, B + 'h102));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1,  1,  0, B + 'h200, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            1, B + 'h1000,   0, 1,  1,  0, B + 'h200, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  1,  0, B + 'h1000, 1, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Wrap at the top of the address space, then reset in the middle of a stall
    apply(mk(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 0, B + 'h1000, 1, 1, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 64'h0, 1, 0, 0, 0));
    // Reset cycle with a redirect present: no flush allowed
    apply(mk(1, 1, 64'h40, 0, 0, 1, 1, 1, 0, 64'h0, 1, 0, 0, 0));
    // BOOT ignores a trap
    apply(mk(0, 0, 0, 1, 64'h1234, 0, 1, 1, 1, B, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, B, 1, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, B + 4, 1, 0, 0, 0));

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
